// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control unit:
// state names, opcode classes, immediate formats, ALU function and PC-op codes.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR,
    OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR,
    OP_B, OP_CBZ,
    OP_BAD
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_ZEXT12,
    IMM_SEXT9,
    IMM_SEXT19,
    IMM_SEXT26
  } imm_fmt_e;

  localparam logic [4:0] FS_PASS_A = 5'b00000;
  localparam logic [4:0] FS_AND    = 5'b00001;
  localparam logic [4:0] FS_ORR    = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01001;

  // PS = 2'b10 (load PC_in) exists in the datapath but no supported instruction issues it.
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b11;

  function automatic op_e decode_op(input logic [10:0] opc);
    op_e op;
    op = OP_BAD;
    casez (opc)
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10001010000: op = OP_AND;
      11'b10101010000: op = OP_ORR;
      11'b1001000100?: op = OP_ADDI;
      11'b1101000100?: op = OP_SUBI;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      11'b000101?????: op = OP_B;
      11'b10110100???: op = OP_CBZ;
      default:         op = OP_BAD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/legv8_control_fsm_if.sv
// Memory request/acknowledge handshake between the control unit (master) and memory (slave).
interface legv8_control_fsm_if;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_read, output mem_write, input mem_ready);
  modport slave  (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/legv8_imm_ext.sv
// Builds the 64-bit datapath constant from the low 26 instruction bits in the selected format.
module legv8_imm_ext
  import legv8_ctrl_pkg::*;
(
  input  logic [25:0] imm_field,
  input  imm_fmt_e    fmt,
  output logic [63:0] constant
);

  always_comb begin
    constant = '0;
    case (fmt)
      IMM_ZEXT12: constant = {52'd0, imm_field[21:10]};
      IMM_SEXT9:  constant = {{55{imm_field[20]}}, imm_field[20:12]};
      IMM_SEXT19: constant = {{45{imm_field[23]}}, imm_field[23:5]};
      IMM_SEXT26: constant = {{38{imm_field[25]}}, imm_field};
      default:    constant = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multicycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM sequencing with a bounded
// memory-wait counter; HALT on illegal opcode or memory timeout.
module legv8_control_fsm
  import legv8_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                IR_out,
  input  logic [3:0]                 status,
  input  logic [3:0]                 SR_out,
  legv8_control_fsm_if.master        mem,
  output logic [4:0]                 DA,
  output logic [4:0]                 SA,
  output logic [4:0]                 SB,
  output logic                       W,
  output logic [4:0]                 FS,
  output logic                       C0,
  output logic [63:0]                constant,
  output logic                       IL,
  output logic                       SL,
  output logic [1:0]                 PS,
  output logic                       PCsel,
  output logic                       Bsel,
  output logic                       EN_ALU,
  output logic                       EN_B,
  output logic                       EN_PC,
  output logic                       EN_ADDR_ALU,
  output logic                       EN_ADDR_PC,
  output logic                       halted,
  output logic                       fault
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  op_e                op;
  imm_fmt_e           imm_fmt;
  logic               rd_req, wr_req;
  logic               waiting, timeout;
  logic [4:0]         rn, rm, rd;
  logic               unused_flags;

  assign op   = decode_op(IR_out[31:21]);
  assign rd   = IR_out[4:0];
  assign rn   = IR_out[9:5];
  assign rm   = IR_out[20:16];

  // Only the live Z flag steers control; the latched flags belong to the datapath.
  assign unused_flags = ^{status[3:1], SR_out};

  assign mem.mem_read  = rd_req;
  assign mem.mem_write = wr_req;
  assign EN_PC         = 1'b0;

  assign waiting = (rd_req | wr_req) & ~mem.mem_ready;
  assign timeout = waiting && (wait_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem.mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = (op == OP_BAD) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = (op == OP_LDUR || op == OP_STUR) ? ST_MEM : ST_FETCH;
      ST_MEM:    if (mem.mem_ready) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
    if (timeout) state_d = ST_HALT;
    // The wait count only survives consecutive stalled cycles within one state.
    wait_d = (waiting && (state_d == state_q)) ? wait_q + 1'b1 : '0;
  end

  always_comb begin
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    DA          = '0;
    SA          = '0;
    SB          = '0;
    W           = 1'b0;
    FS          = FS_PASS_A;
    C0          = 1'b0;
    IL          = 1'b0;
    SL          = 1'b0;
    PS          = PS_HOLD;
    PCsel       = 1'b0;
    Bsel        = 1'b0;
    EN_ALU      = 1'b0;
    EN_B        = 1'b0;
    EN_ADDR_ALU = 1'b0;
    EN_ADDR_PC  = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    imm_fmt     = IMM_NONE;
    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          EN_ADDR_PC = 1'b1;
          rd_req     = 1'b1;
          if (mem.mem_ready) begin
            IL = 1'b1;
            PS = PS_INC;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
              SA     = rn;
              SB     = rm;
              DA     = rd;
              EN_ALU = 1'b1;
              W      = 1'b1;
              SL     = 1'b1;
              case (op)
                OP_SUB, OP_SUBI: begin
                  FS = FS_SUB;
                  C0 = 1'b1;
                end
                OP_AND:  FS = FS_AND;
                OP_ORR:  FS = FS_ORR;
                default: FS = FS_ADD;
              endcase
              if (op == OP_ADDI || op == OP_SUBI) begin
                Bsel    = 1'b1;
                imm_fmt = IMM_ZEXT12;
              end
            end
            OP_LDUR, OP_STUR: begin
              SA          = rn;
              FS          = FS_ADD;
              Bsel        = 1'b1;
              imm_fmt     = IMM_SEXT9;
              EN_ADDR_ALU = 1'b1;
            end
            OP_B: begin
              imm_fmt = IMM_SEXT26;
              PCsel   = 1'b1;
              PS      = PS_REL;
            end
            OP_CBZ: begin
              SA = rd;
              FS = FS_PASS_A;
              if (status[0]) begin
                imm_fmt = IMM_SEXT19;
                PCsel   = 1'b1;
                PS      = PS_REL;
              end
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          SA          = rn;
          FS          = FS_ADD;
          Bsel        = 1'b1;
          imm_fmt     = IMM_SEXT9;
          EN_ADDR_ALU = 1'b1;
          if (op == OP_STUR) begin
            wr_req = 1'b1;
            SB     = rd;
            EN_B   = 1'b1;
          end else begin
            rd_req = 1'b1;
            DA     = rd;
            W      = mem.mem_ready;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  legv8_imm_ext u_imm_ext (
    .imm_field (IR_out[25:0]),
    .fmt       (imm_fmt),
    .constant  (constant)
  );

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Directed bench: each instruction expands into a per-cycle trace of expected control words,
// replayed against the DUT with the memory-ready pattern that trace assumes.
module tb_legv8_control_fsm;
  import legv8_ctrl_pkg::*;

  localparam int MAX_WAIT = 16;

  logic        clock, reset;
  logic [31:0] IR_out;
  logic [3:0]  status, SR_out;
  logic [4:0]  DA, SA, SB, FS;
  logic        W, C0, IL, SL, PCsel, Bsel, EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC, halted, fault;
  logic [63:0] constant;
  logic [1:0]  PS;

  legv8_control_fsm_if bus ();

  legv8_control_fsm #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .IR_out(IR_out), .status(status), .SR_out(SR_out),
    .mem(bus), .DA(DA), .SA(SA), .SB(SB), .W(W), .FS(FS), .C0(C0), .constant(constant),
    .IL(IL), .SL(SL), .PS(PS), .PCsel(PCsel), .Bsel(Bsel), .EN_ALU(EN_ALU), .EN_B(EN_B),
    .EN_PC(EN_PC), .EN_ADDR_ALU(EN_ADDR_ALU), .EN_ADDR_PC(EN_ADDR_PC),
    .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic        mem_read, mem_write;
    logic [4:0]  da, sa, sb;
    logic        w;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        il, sl;
    logic [1:0]  ps;
    logic        pcsel, bsel, en_alu, en_b, en_pc, en_addr_alu, en_addr_pc, halted, fault;
  } ctrl_t;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [31:0] ir;
    logic        z;
    ctrl_t       exp;
    string       tag;
  } step_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR, K_STUR, K_B, K_CBZ, K_BAD} kind_e;

  ctrl_t act;
  assign act = {bus.mem_read, bus.mem_write, DA, SA, SB, W, FS, C0, constant, IL, SL, PS,
                PCsel, Bsel, EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC, halted, fault};

  step_t plan[$];
  int    checks = 0, failures = 0;
  ctrl_t exp_cur;
  string tag_cur;
  int    idx_cur;
  bit    chk_en = 0, done = 0, plan_ready = 0;
  int    s_add, e_add, s_ldur, e_ldur, s_cbz1, s_cbz0, e_stur_part, s_bad, e_bad, s_to, e_to;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic kind_e kind_of(logic [31:0] ir);
    logic [10:0] op;
    op = ir[31:21];
    if (op == 11'b10001011000) return K_ADD;
    if (op == 11'b11001011000) return K_SUB;
    if (op == 11'b10001010000) return K_AND;
    if (op == 11'b10101010000) return K_ORR;
    if (op[10:1] == 10'b1001000100) return K_ADDI;
    if (op[10:1] == 10'b1101000100) return K_SUBI;
    if (op == 11'b11111000010) return K_LDUR;
    if (op == 11'b11111000000) return K_STUR;
    if (ir[31:26] == 6'b000101) return K_B;
    if (ir[31:24] == 8'b10110100) return K_CBZ;
    return K_BAD;
  endfunction

  function automatic void add_step(logic rst_n, logic rdy, logic [31:0] ir, logic z, ctrl_t e, string tag);
    step_t s;
    s.rst_n = rst_n; s.rdy = rdy; s.ir = ir; s.z = z; s.exp = e; s.tag = tag;
    plan.push_back(s);
  endfunction

  function automatic void add_reset(int n);
    for (int i = 0; i < n; i++) add_step(1'b0, 1'b0, 32'h0, 1'b0, '0, "reset");
  endfunction

  function automatic void add_halt(int n, logic [31:0] ir);
    ctrl_t e;
    e = '0; e.halted = 1'b1; e.fault = 1'b1;
    for (int i = 0; i < n; i++) add_step(1'b1, 1'b0, ir, 1'b0, e, "halt");
  endfunction

  // One instruction: fw stalled fetch cycles, then (if the fetch completes) decode, execute
  // and, for loads/stores, mw stalled memory cycles plus the ready cycle when full=1.
  function automatic void expand(logic [31:0] ir, logic z, int fw, int mw, bit full);
    ctrl_t e, base;
    kind_e k;
    logic signed [8:0]  s9;
    logic signed [18:0] s19;
    logic signed [25:0] s26;
    k = kind_of(ir);
    for (int i = 0; i < fw && i < MAX_WAIT; i++) begin
      e = '0; e.mem_read = 1'b1; e.en_addr_pc = 1'b1;
      add_step(1'b1, 1'b0, ir, z, e, "fetch_wait");
    end
    if (fw >= MAX_WAIT) begin
      add_halt(3, ir);
      return;
    end
    e = '0; e.mem_read = 1'b1; e.en_addr_pc = 1'b1; e.il = 1'b1; e.ps = 2'b01;
    add_step(1'b1, 1'b1, ir, z, e, "fetch");
    add_step(1'b1, 1'b0, ir, z, '0, "decode");
    if (k == K_BAD) begin
      add_halt(10, ir);
      return;
    end
    e = '0;
    case (k)
      K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
        e.sa = ir[9:5]; e.sb = ir[20:16]; e.da = ir[4:0];
        e.w = 1'b1; e.sl = 1'b1; e.en_alu = 1'b1;
        e.fs = (k == K_SUB || k == K_SUBI) ? FS_SUB : (k == K_AND) ? FS_AND : (k == K_ORR) ? FS_ORR : FS_ADD;
        e.c0 = (k == K_SUB || k == K_SUBI);
        if (k == K_ADDI || k == K_SUBI) begin
          e.bsel = 1'b1;
          e.k = 64'(ir[21:10]);
        end
        add_step(1'b1, 1'b0, ir, z, e, "exec_alu");
      end
      K_LDUR, K_STUR: begin
        s9 = ir[20:12];
        e.sa = ir[9:5]; e.fs = FS_ADD; e.bsel = 1'b1; e.k = 64'(s9); e.en_addr_alu = 1'b1;
        add_step(1'b1, 1'b0, ir, z, e, "exec_addr");
        base = e;
        if (k == K_STUR) begin
          base.mem_write = 1'b1; base.sb = ir[4:0]; base.en_b = 1'b1;
        end else begin
          base.mem_read = 1'b1; base.da = ir[4:0];
        end
        for (int i = 0; i < mw; i++) add_step(1'b1, 1'b0, ir, z, base, "mem_wait");
        if (full) begin
          if (k == K_LDUR) base.w = 1'b1;
          add_step(1'b1, 1'b1, ir, z, base, "mem");
        end
      end
      K_B: begin
        s26 = ir[25:0];
        e.k = 64'(s26); e.pcsel = 1'b1; e.ps = 2'b11;
        add_step(1'b1, 1'b0, ir, z, e, "exec_b");
      end
      K_CBZ: begin
        e.sa = ir[4:0]; e.fs = FS_PASS_A;
        if (z) begin
          s19 = ir[23:5];
          e.k = 64'(s19); e.pcsel = 1'b1; e.ps = 2'b11;
        end
        add_step(1'b1, 1'b0, ir, z, e, "exec_cbz");
      end
      default: ;
    endcase
  endfunction

  // Stimulus: build the trace, then replay it one step per cycle.
  initial begin : drive
    logic [31:0] ir_add, ir_sub, ir_and, ir_orr, ir_addi, ir_subi, ir_ldur, ir_stur, ir_b, ir_cbz;
    reset = 1'b0; bus.mem_ready = 1'b0; IR_out = '0; status = '0; SR_out = '0;
    ir_add  = 32'h8B02_0023;
    ir_sub  = {11'b11001011000, 5'd5, 6'd0, 5'd6, 5'd7};
    ir_and  = {11'b10001010000, 5'd10, 6'd0, 5'd11, 5'd12};
    ir_orr  = {11'b10101010000, 5'd13, 6'd0, 5'd14, 5'd15};
    ir_addi = {10'b1001000100, 12'hABC, 5'd2, 5'd9};
    ir_subi = {10'b1101000100, 12'h001, 5'd31, 5'd0};
    ir_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd5};
    ir_stur = {11'b11111000000, 9'h010, 2'b00, 5'd8, 5'd6};
    ir_b    = {6'b000101, 26'h3FF_FFFE};
    ir_cbz  = {8'b10110100, 19'd3, 5'd7};

    add_reset(3);
    s_add = plan.size(); expand(ir_add, 1'b0, 0, 0, 1'b1); e_add = plan.size();
    expand(ir_sub, 1'b0, 2, 0, 1'b1);
    expand(ir_and, 1'b1, 0, 0, 1'b1);
    expand(ir_orr, 1'b0, 1, 0, 1'b1);
    expand(ir_addi, 1'b0, 0, 0, 1'b1);
    expand(ir_subi, 1'b0, 0, 0, 1'b1);
    s_ldur = plan.size(); expand(ir_ldur, 1'b0, 0, 2, 1'b1); e_ldur = plan.size();
    expand(ir_stur, 1'b0, 0, 0, 1'b1);
    expand(ir_b, 1'b0, 0, 0, 1'b1);
    s_cbz1 = plan.size(); expand(ir_cbz, 1'b1, 0, 0, 1'b1);
    s_cbz0 = plan.size(); expand(ir_cbz, 1'b0, 0, 0, 1'b1);
    expand(ir_stur, 1'b0, 0, 1, 1'b0); e_stur_part = plan.size();
    add_reset(2);
    expand(ir_add, 1'b0, 0, 0, 1'b1);
    s_bad = plan.size(); expand(32'h0000_0000, 1'b0, 0, 0, 1'b1); e_bad = plan.size();
    add_reset(2);
    s_to = plan.size(); expand(ir_add, 1'b0, MAX_WAIT, 0, 1'b1); e_to = plan.size();
    add_reset(2);
    expand(ir_ldur, 1'b1, 1, 0, 1'b1);
    plan_ready = 1'b1;

    foreach (plan[i]) begin
      @(negedge clock);
      reset         = plan[i].rst_n;
      bus.mem_ready = plan[i].rdy;
      IR_out        = plan[i].ir;
      status        = {3'($urandom), plan[i].z};
      SR_out        = 4'($urandom);
      exp_cur       = plan[i].exp;
      tag_cur       = plan[i].tag;
      idx_cur       = i;
      chk_en        = 1'b1;
    end
    @(negedge clock);
    chk_en = 1'b0;
    done   = 1'b1;
  end

  task automatic pin(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL pin_%s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Compare: hand-computed pins on the trace, then every cycle DUT vs trace.
  initial begin : compare
    int          il_cnt, rd_cnt, halt_cnt;
    logic [5:0]  wbits;
    wait (plan_ready);
    pin("add_len", 64'(e_add - s_add), 64'd3);
    pin("add_regs", 64'({plan[s_add+2].exp.sa, plan[s_add+2].exp.sb, plan[s_add+2].exp.da}), 64'({5'd1, 5'd2, 5'd3}));
    pin("add_w_sl_alu", 64'({plan[s_add+2].exp.w, plan[s_add+2].exp.sl, plan[s_add+2].exp.en_alu}), 64'b111);
    pin("ldur_len", 64'(e_ldur - s_ldur), 64'd6);
    pin("ldur_const", plan[s_ldur+2].exp.k, 64'hFFFF_FFFF_FFFF_FFF8);
    wbits = '0;
    for (int i = s_ldur; i < e_ldur; i++) wbits = {wbits[4:0], plan[i].exp.w};
    pin("ldur_w_pattern", 64'(wbits), 64'b000001);
    pin("cbz_taken_ps", 64'(plan[s_cbz1+2].exp.ps), 64'd3);
    pin("cbz_taken_const", plan[s_cbz1+2].exp.k, 64'd3);
    pin("cbz_not_taken_ps", 64'(plan[s_cbz0+2].exp.ps), 64'd0);
    pin("cbz_sl", 64'({plan[s_cbz1+2].exp.sl, plan[s_cbz0+2].exp.sl}), 64'd0);
    pin("stur_mem_write", 64'(plan[e_stur_part-1].exp.mem_write), 64'd1);
    halt_cnt = 0;
    for (int i = s_bad; i < e_bad; i++) halt_cnt += int'(plan[i].exp.halted & plan[i].exp.fault);
    pin("illegal_halt_cycles", 64'(halt_cnt), 64'd10);
    il_cnt = 0; rd_cnt = 0;
    for (int i = s_to; i < e_to; i++) begin
      il_cnt += int'(plan[i].exp.il);
      rd_cnt += int'(plan[i].exp.mem_read);
    end
    pin("timeout_il", 64'(il_cnt), 64'd0);
    pin("timeout_fetch_cycles", 64'(rd_cnt), 64'(MAX_WAIT));

    while (!done) begin
      @(negedge clock);
      #2;
      if (chk_en && !done) begin
        checks++;
        if (act !== exp_cur) begin
          failures++;
          $display("FAIL step%0d %s: got=%h want=%h", idx_cur, tag_cur, act, exp_cur);
        end
        checks++;
        if (int'(EN_ALU) + int'(EN_B) + int'(EN_PC) + int'(bus.mem_read) > 1 ||
            int'(EN_ADDR_ALU) + int'(EN_ADDR_PC) > 1) begin
          failures++;
          $display("FAIL step%0d bus_enables: data(alu,b,pc,mem)=%b%b%b%b addr(alu,pc)=%b%b want at most one of each",
                   idx_cur, EN_ALU, EN_B, EN_PC, bus.mem_read, EN_ADDR_ALU, EN_ADDR_PC);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule
